// File: rtl/time_bcd_decoder.sv
// Binary time (hh:mm:ss) to packed-BCD decoder with range check, clamp/blank and 12h mapping.
// Each field is converted by sequential double dabble, one bit per cycle, all three in parallel.
module time_bcd_decoder #(
  parameter int W      = 8,
  parameter int SAT_EN = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         mode_12h,
  input  logic [W-1:0] hours_in,
  input  logic [W-1:0] minutes_in,
  input  logic [W-1:0] seconds_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   hours_out,
  output logic [7:0]   minutes_out,
  output logic [7:0]   seconds_out,
  output logic         PM_LED,
  output logic         err
);

  localparam logic [1:0]   IDLE  = 2'd0;
  localparam logic [1:0]   CONV  = 2'd1;
  localparam logic [1:0]   DONE  = 2'd2;
  localparam logic [W-1:0] HMAX  = W'(23);
  localparam logic [W-1:0] MSMAX = W'(59);
  localparam logic [W-1:0] NOON  = W'(12);
  localparam logic [3:0]   LAST  = 4'(W - 1);
  localparam bit           BLANK = (SAT_EN == 0);

  logic [1:0]   state;
  logic [3:0]   bit_cnt;
  logic [W-1:0] h_bin, m_bin, s_bin;
  logic [7:0]   h_bcd, m_bcd, s_bcd;
  logic [7:0]   h_next, m_next, s_next;
  logic [2:0]   oor_q;
  logic         pm_q;
  logic         h_oor, m_oor, s_oor;
  logic [W-1:0] h_clamp, m_clamp, s_clamp, h_disp;

  // One double-dabble step: correct each digit >= 5, then shift the next binary bit in.
  function automatic logic [7:0] dd_step(input logic [7:0] bcd, input logic msb);
    logic [7:0] adj;
    adj = bcd;
    if (adj[3:0] >= 4'd5) adj[3:0] = adj[3:0] + 4'd3;
    if (adj[7:4] >= 4'd5) adj[7:4] = adj[7:4] + 4'd3;
    return {adj[6:0], msb};
  endfunction

  // The hour is always clamped so PM and the 12h mapping stay meaningful even when blanking.
  always_comb begin
    h_oor   = hours_in > HMAX;
    m_oor   = minutes_in > MSMAX;
    s_oor   = seconds_in > MSMAX;
    h_clamp = h_oor ? HMAX : hours_in;
    m_clamp = m_oor ? MSMAX : minutes_in;
    s_clamp = s_oor ? MSMAX : seconds_in;
    h_disp  = h_clamp;
    if (mode_12h) begin
      if (h_clamp == '0)
        h_disp = NOON;
      else if (h_clamp > NOON)
        h_disp = h_clamp - NOON;
    end
  end

  assign h_next    = dd_step(h_bcd, h_bin[W-1]);
  assign m_next    = dd_step(m_bcd, m_bin[W-1]);
  assign s_next    = dd_step(s_bcd, s_bin[W-1]);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // The final shift lands on the CONV->DONE edge, so the outputs take the step result directly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      h_bin       <= '0;
      m_bin       <= '0;
      s_bin       <= '0;
      h_bcd       <= '0;
      m_bcd       <= '0;
      s_bcd       <= '0;
      oor_q       <= '0;
      pm_q        <= 1'b0;
      hours_out   <= '0;
      minutes_out <= '0;
      seconds_out <= '0;
      PM_LED      <= 1'b0;
      err         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state   <= CONV;
            bit_cnt <= '0;
            h_bin   <= h_disp;
            m_bin   <= m_clamp;
            s_bin   <= s_clamp;
            h_bcd   <= '0;
            m_bcd   <= '0;
            s_bcd   <= '0;
            oor_q   <= {h_oor, m_oor, s_oor};
            pm_q    <= mode_12h && (h_clamp >= NOON);
          end
        end
        CONV: begin
          h_bcd   <= h_next;
          m_bcd   <= m_next;
          s_bcd   <= s_next;
          h_bin   <= h_bin << 1;
          m_bin   <= m_bin << 1;
          s_bin   <= s_bin << 1;
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt == LAST) begin
            state       <= DONE;
            bit_cnt     <= '0;
            hours_out   <= (BLANK && oor_q[2]) ? 8'hFF : h_next;
            minutes_out <= (BLANK && oor_q[1]) ? 8'hFF : m_next;
            seconds_out <= (BLANK && oor_q[0]) ? 8'hFF : s_next;
            PM_LED      <= pm_q;
            err         <= |oor_q;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/time_bcd_decoder.md
TIME_BCD_DECODER -- requirements
Module: time_bcd_decoder

Interface
REQ-001 Parameter W, default 8: bit width of each binary time input field; legal range 6..10.
REQ-002 Parameter SAT_EN, default 1: 1 = clamp out-of-range fields; 0 = blank out-of-range fields to 8'hFF.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 in_valid  in  1  input time fields are valid.
REQ-007 in_ready  out  1  block can accept a time; high only in IDLE.
REQ-008 mode_12h  in  1  selects 12-hour display when 1, 24-hour when 0; sampled at accept.
REQ-009 hours_in, minutes_in, seconds_in  in  W each  binary time fields.
REQ-010 out_valid  out  1  decoded result is valid.
REQ-011 out_ready  in  1  consumer accepts the result.
REQ-012 hours_out, minutes_out, seconds_out  out  8 each  two-digit packed BCD, tens digit in [7:4].
REQ-013 PM_LED  out  1  PM indicator.
REQ-014 err  out  1  at least one input field was out of range.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, CONV and DONE.
REQ-016 IDLE -> CONV on a rising edge with in_valid && in_ready.
REQ-017 CONV -> DONE after exactly W CONV cycles.
REQ-018 DONE -> IDLE on a rising edge with out_valid && out_ready.
REQ-019 Accept edge: all inputs and mode_12h SHALL be registered; later input changes SHALL have no effect.
REQ-020 Range check at accept: hours > 23, minutes > 59 or seconds > 59 marks that field out of range; err = OR of the three flags.
REQ-021 With SAT_EN=1, an out-of-range field SHALL be clamped to 23 (hours) or 59 (minutes, seconds) before conversion.
REQ-022 With SAT_EN=0, an out-of-range field's output SHALL be 8'hFF; all other fields SHALL convert normally.
REQ-023 12-hour mapping, applied to the clamped hour at accept: 0 -> 12, 1..12 unchanged, 13..23 -> h-12.
REQ-024 PM_LED SHALL equal (clamped hour >= 12) when mode_12h=1, and SHALL be 0 when mode_12h=0.
REQ-025 Conversion SHALL be sequential shift-add-3 (double dabble), one bit per CONV cycle, with all three fields converted in parallel.
REQ-026 Each BCD digit >= 5 SHALL get +3 before each shift; BCD scratch width is 8 bits per field.
REQ-027 out_valid SHALL rise on the W-th rising edge after the accept edge (latency W cycles, 8 at default).
REQ-028 hours_out, minutes_out, seconds_out, PM_LED and err SHALL update only on the CONV->DONE edge.
REQ-029 Those outputs SHALL hold their values from the CONV->DONE edge until the next CONV->DONE edge, including across IDLE.
REQ-030 in_ready SHALL be 0 in CONV and DONE; in_valid in those states SHALL be ignored and not queued.
REQ-031 A handshake in DONE returns the FSM to IDLE; a new accept SHALL occur no earlier than the following edge.
REQ-032 Any number of DONE cycles with out_ready=0 SHALL leave all outputs stable and out_valid=1.
REQ-033 No combinational path SHALL exist from inputs to outputs, except in_ready and out_valid, which are decoded from the state only.

Reset
REQ-034 reset_n=0 SHALL immediately force IDLE.
REQ-035 Reset values: out_valid=0, in_ready=1 (while reset_n=0 and in IDLE), all BCD outputs 8'h00, PM_LED=0, err=0, shift counter 0.
REQ-036 Reset in CONV or DONE SHALL abort the transaction with no result produced; the first accept after release SHALL convert correctly.

Verification
REQ-037 24h mode, 13:45:07 -> 8'h13/8'h45/8'h07, PM_LED=0, err=0; out_valid exactly 8 cycles after the accept edge.
REQ-038 12h mode: 00:00:00 -> 8'h12, PM_LED=0; 12:30:59 -> 8'h12/8'h30/8'h59, PM_LED=1; 23:59:59 -> 8'h11, PM_LED=1.
REQ-039 Input 24:60:255: SAT_EN=1 -> 8'h23/8'h59/8'h59 with err=1; SAT_EN=0 -> 8'hFF on all three fields with err=1.
REQ-040 out_ready held low 5 cycles in DONE with in_valid pulsed meanwhile -> outputs stable, in_ready=0, no second accept; release -> IDLE next edge.
REQ-041 reset_n pulsed low at CONV cycle 4 -> all outputs 0 immediately; next transaction 09:05:03 -> 8'h09/8'h05/8'h03.
REQ-042 Sweep hours 0..2^W-1 with minutes=seconds=0, 24h mode, SAT_EN=1 -> hours 0..23 give matching BCD; all hours >= 24 give 8'h23 with err=1.
